// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: forwarding select codes, special register numbers,
// the destination-tag record carried alongside ID_EX, EX_MEM and MEM_WB, and the stall FSM encoding.
package pipe_pkg;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_EX  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;
    localparam logic [1:0] FWD_WB  = 2'b11;

    localparam logic [3:0] REG_LR = 4'd14;
    localparam logic [3:0] REG_PC = 4'd15;

    typedef struct packed {
        logic       valid;
        logic [3:0] dest;
        logic       is_load;
    } tag_t;

    localparam int   TAG_W      = $bits(tag_t);
    localparam tag_t TAG_BUBBLE = '{valid: 1'b0, dest: 4'd0, is_load: 1'b0};

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_STALL = 1'b1
    } stall_state_t;

    localparam int STALL_CNT_W = 2;

    // load_ok=0 refuses a producer whose value is still in flight from memory.
    function automatic logic fwd_hit(tag_t t, logic use_src, logic [3:0] src, logic load_ok);
        return use_src && t.valid && (t.dest == src) && (src != REG_PC) &&
               (load_ok || !t.is_load);
    endfunction

endpackage

// File: rtl/fwd_select.sv
// Operand forwarding select for one source register: picks the youngest in-flight
// producer (EX > MEM > WB), otherwise the register file.
module fwd_select
    import pipe_pkg::*;
(
    input  logic [3:0]       src_i,
    input  logic             use_i,
    input  logic [TAG_W-1:0] ex_tag_i,
    input  logic [TAG_W-1:0] mem_tag_i,
    input  logic [TAG_W-1:0] wb_tag_i,
    output logic [1:0]       sel_o
);

    tag_t ex_t;
    tag_t mem_t;
    tag_t wb_t;

    assign ex_t  = tag_t'(ex_tag_i);
    assign mem_t = tag_t'(mem_tag_i);
    assign wb_t  = tag_t'(wb_tag_i);

    // A load sitting in EX has no data yet, so it falls through to the older stages.
    always_comb begin
        sel_o = FWD_RF;
        if (fwd_hit(ex_t, use_i, src_i, 1'b0)) begin
            sel_o = FWD_EX;
        end else if (fwd_hit(mem_t, use_i, src_i, 1'b1)) begin
            sel_o = FWD_MEM;
        end else if (fwd_hit(wb_t, use_i, src_i, 1'b1)) begin
            sel_o = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_forward_ctrl.sv
// Hazard and forwarding controller for the 5-stage pipeline: destination-tag shadow pipe,
// load-use stall FSM with down-counter, branch flush, forwarding selects and a stall counter.
//
//   state    | meaning
//   ST_IDLE  | no stall pending; a load-use hazard stalls combinationally this cycle
//   ST_STALL | extra bubbles still owed; cnt_q counts the remaining stall cycles
module hazard_forward_ctrl
    import pipe_pkg::*;
#(
    parameter int LOAD_USE_STALLS = 1,
    parameter int PERF_W          = 16
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [3:0]        ID_Rn,
    input  logic [3:0]        ID_Rm,
    input  logic [3:0]        ID_Rd,
    input  logic              ID_use_Rn,
    input  logic              ID_use_Rm,
    input  logic              ID_use_Rd,
    input  logic              ID_RF_enable,
    input  logic              ID_load_instr,
    input  logic              ID_BL_instr,
    input  logic              EX_branch_taken,
    output logic              PC_enable,
    output logic              IF_ID_enable,
    output logic              IF_ID_flush,
    output logic              NOP_select,
    output logic [1:0]        fwd_A,
    output logic [1:0]        fwd_B,
    output logic [1:0]        fwd_C,
    output logic [PERF_W-1:0] stall_cycles
);

    localparam logic [STALL_CNT_W-1:0] STALL_INIT = STALL_CNT_W'(LOAD_USE_STALLS - 1);
    localparam logic [STALL_CNT_W-1:0] CNT_ONE    = STALL_CNT_W'(1);
    localparam logic [PERF_W-1:0]      PERF_ONE   = PERF_W'(1);

    tag_t id_tag;
    tag_t ex_tag_q, ex_tag_d;
    tag_t mem_tag_q;
    tag_t wb_tag_q;

    stall_state_t           state_q;
    logic [STALL_CNT_W-1:0] cnt_q;
    logic [PERF_W-1:0]      perf_q, perf_d;

    logic hazard;
    logic branch;
    logic stall;
    logic use_rn, use_rm, use_rd;

    // While reset is asserted nothing is considered used, so all selects stay at RF.
    assign use_rn = ID_use_Rn & Reset;
    assign use_rm = ID_use_Rm & Reset;
    assign use_rd = ID_use_Rd & Reset;

    always_comb begin
        id_tag         = TAG_BUBBLE;
        id_tag.valid   = ID_RF_enable | ID_BL_instr;
        id_tag.dest    = ID_BL_instr ? REG_LR : ID_Rd;
        id_tag.is_load = ID_load_instr;
    end

    always_comb begin
        hazard = ex_tag_q.is_load &&
                 (fwd_hit(ex_tag_q, use_rn, ID_Rn, 1'b1) ||
                  fwd_hit(ex_tag_q, use_rm, ID_Rm, 1'b1) ||
                  fwd_hit(ex_tag_q, use_rd, ID_Rd, 1'b1));
        branch = Reset && EX_branch_taken;
        stall  = Reset && ((state_q == ST_STALL) || hazard);

        // A taken branch squashes the held instruction, so it beats any stall.
        PC_enable    = !(stall && !branch);
        IF_ID_enable = !(stall && !branch);
        IF_ID_flush  = branch;
        NOP_select   = stall || branch;

        ex_tag_d = NOP_select ? TAG_BUBBLE : id_tag;

        perf_d = perf_q;
        if (stall && !branch && (perf_q != {PERF_W{1'b1}})) begin
            perf_d = perf_q + PERF_ONE;
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else if (branch) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (hazard) begin
                        cnt_q <= STALL_INIT;
                        if (STALL_INIT != '0) begin
                            state_q <= ST_STALL;
                        end
                    end
                end
                ST_STALL: begin
                    cnt_q <= cnt_q - CNT_ONE;
                    if (cnt_q <= CNT_ONE) begin
                        state_q <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            ex_tag_q  <= TAG_BUBBLE;
            mem_tag_q <= TAG_BUBBLE;
            wb_tag_q  <= TAG_BUBBLE;
            perf_q    <= '0;
        end else begin
            ex_tag_q  <= ex_tag_d;
            mem_tag_q <= ex_tag_q;
            wb_tag_q  <= mem_tag_q;
            perf_q    <= perf_d;
        end
    end

    assign stall_cycles = perf_q;

    fwd_select u_fwd_a (
        .src_i     (ID_Rn),
        .use_i     (use_rn),
        .ex_tag_i  (ex_tag_q),
        .mem_tag_i (mem_tag_q),
        .wb_tag_i  (wb_tag_q),
        .sel_o     (fwd_A)
    );

    fwd_select u_fwd_b (
        .src_i     (ID_Rm),
        .use_i     (use_rm),
        .ex_tag_i  (ex_tag_q),
        .mem_tag_i (mem_tag_q),
        .wb_tag_i  (wb_tag_q),
        .sel_o     (fwd_B)
    );

    fwd_select u_fwd_c (
        .src_i     (ID_Rd),
        .use_i     (use_rd),
        .ex_tag_i  (ex_tag_q),
        .mem_tag_i (mem_tag_q),
        .wb_tag_i  (wb_tag_q),
        .sel_o     (fwd_C)
    );

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// Self-checking bench: two controller instances (1 and 2 load-use bubbles) driven in lockstep,
// checked against a history-based reference model plus a directed vector table and corner sequences.
module tb_hazard_forward_ctrl;

    logic       Clk = 1'b0;
    logic       Reset;
    logic [3:0] ID_Rn, ID_Rm, ID_Rd;
    logic       ID_use_Rn, ID_use_Rm, ID_use_Rd;
    logic       ID_RF_enable, ID_load_instr, ID_BL_instr, EX_branch_taken;

    logic       pc_en[2], ifid_en[2], flush[2], nop_sel[2];
    logic [1:0] fa[2], fb[2], fc[2];
    logic [15:0] sc1;
    logic [3:0]  sc2;

    int checks = 0;
    int errors = 0;

    always #5 Clk = ~Clk;

    hazard_forward_ctrl #(.LOAD_USE_STALLS(1), .PERF_W(16)) u1 (
        .Clk(Clk), .Reset(Reset), .ID_Rn(ID_Rn), .ID_Rm(ID_Rm), .ID_Rd(ID_Rd),
        .ID_use_Rn(ID_use_Rn), .ID_use_Rm(ID_use_Rm), .ID_use_Rd(ID_use_Rd),
        .ID_RF_enable(ID_RF_enable), .ID_load_instr(ID_load_instr), .ID_BL_instr(ID_BL_instr),
        .EX_branch_taken(EX_branch_taken), .PC_enable(pc_en[0]), .IF_ID_enable(ifid_en[0]),
        .IF_ID_flush(flush[0]), .NOP_select(nop_sel[0]), .fwd_A(fa[0]), .fwd_B(fb[0]),
        .fwd_C(fc[0]), .stall_cycles(sc1));

    hazard_forward_ctrl #(.LOAD_USE_STALLS(2), .PERF_W(4)) u2 (
        .Clk(Clk), .Reset(Reset), .ID_Rn(ID_Rn), .ID_Rm(ID_Rm), .ID_Rd(ID_Rd),
        .ID_use_Rn(ID_use_Rn), .ID_use_Rm(ID_use_Rm), .ID_use_Rd(ID_use_Rd),
        .ID_RF_enable(ID_RF_enable), .ID_load_instr(ID_load_instr), .ID_BL_instr(ID_BL_instr),
        .EX_branch_taken(EX_branch_taken), .PC_enable(pc_en[1]), .IF_ID_enable(ifid_en[1]),
        .IF_ID_flush(flush[1]), .NOP_select(nop_sel[1]), .fwd_A(fa[1]), .fwd_B(fb[1]),
        .fwd_C(fc[1]), .stall_cycles(sc2));

    // Reference model: the instructions that most recently left ID (0=EX, 1=MEM, 2=WB).
    typedef struct { bit wr; int dest; bit ld; } rec_t;
    rec_t hist[2][3];
    int   left[2];
    int   perf[2];
    int   nbub[2] = '{1, 2};
    int   pmax[2] = '{65535, 15};

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit reads(bit u, int src, int dest);
        return u && (src == dest) && (src != 15);
    endfunction

    function automatic bit hazard_exp(int k);
        rec_t e = hist[k][0];
        if (!Reset || !e.wr || !e.ld) return 0;
        return reads(ID_use_Rn, ID_Rn, e.dest) || reads(ID_use_Rm, ID_Rm, e.dest) ||
               reads(ID_use_Rd, ID_Rd, e.dest);
    endfunction

    function automatic int fwd_exp(int k, bit u, int src);
        if (!Reset || !u || src == 15) return 0;
        for (int s = 0; s < 3; s++) begin
            if (hist[k][s].wr && hist[k][s].dest == src && !(s == 0 && hist[k][s].ld))
                return s + 1;
        end
        return 0;
    endfunction

    task automatic model_update(int k);
        bit   haz, st, br;
        rec_t nr;
        if (!Reset) begin
            for (int s = 0; s < 3; s++) hist[k][s] = '{0, 0, 0};
            left[k] = 0;
            perf[k] = 0;
            return;
        end
        haz = hazard_exp(k);
        st  = (left[k] > 0) || haz;
        br  = EX_branch_taken;
        if (st && !br && perf[k] < pmax[k]) perf[k]++;
        nr.wr   = ID_RF_enable || ID_BL_instr;
        nr.dest = ID_BL_instr ? 14 : int'(ID_Rd);
        nr.ld   = ID_load_instr;
        if (st || br) nr = '{0, 0, 0};
        hist[k][2] = hist[k][1];
        hist[k][1] = hist[k][0];
        hist[k][0] = nr;
        if (br)              left[k] = 0;
        else if (left[k] > 0) left[k] = left[k] - 1;
        else if (haz)         left[k] = nbub[k] - 1;
    endtask

    // One clock cycle: compare both instances against the model, then advance model and DUT.
    task automatic step();
        #1;
        for (int k = 0; k < 2; k++) begin
            bit    st, br;
            string p;
            p  = $sformatf("u%0d", k + 1);
            st = Reset && ((left[k] > 0) || hazard_exp(k));
            br = Reset && EX_branch_taken;
            check({p, ".PC_enable"},    pc_en[k],   !(st && !br));
            check({p, ".IF_ID_enable"}, ifid_en[k], !(st && !br));
            check({p, ".IF_ID_flush"},  flush[k],   br);
            check({p, ".NOP_select"},   nop_sel[k], st || br);
            check({p, ".fwd_A"}, fa[k], fwd_exp(k, ID_use_Rn, ID_Rn));
            check({p, ".fwd_B"}, fb[k], fwd_exp(k, ID_use_Rm, ID_Rm));
            check({p, ".fwd_C"}, fc[k], fwd_exp(k, ID_use_Rd, ID_Rd));
            check({p, ".stall_cycles"}, (k == 0) ? {16'd0, sc1} : {28'd0, sc2}, perf[k]);
        end
        @(posedge Clk);
        for (int k = 0; k < 2; k++) model_update(k);
        @(negedge Clk);
    endtask

    task automatic set_id(input logic [3:0] rn, rm, rd, input logic urn, urm, urd, rfe, ld, bl, br);
        ID_Rn = rn; ID_Rm = rm; ID_Rd = rd;
        ID_use_Rn = urn; ID_use_Rm = urm; ID_use_Rd = urd;
        ID_RF_enable = rfe; ID_load_instr = ld; ID_BL_instr = bl; EX_branch_taken = br;
    endtask

    task automatic do_reset();
        Reset = 1'b0;
        step();
        Reset = 1'b1;
    endtask

    typedef struct {
        logic [3:0] rn, rm, rd;
        logic       urn, urm, urd, rfe, ld, bl, br;
        logic       pc, nop, fl;
        logic [1:0] fa, fb, fc;
    } vec_t;

    vec_t vecs[17];

    function automatic vec_t mk(logic [3:0] rn, rm, rd, logic urn, urm, urd, rfe, ld, bl, br,
                                logic pc, nop, fl, logic [1:0] a, b, c);
        vec_t v;
        v.rn = rn; v.rm = rm; v.rd = rd; v.urn = urn; v.urm = urm; v.urd = urd;
        v.rfe = rfe; v.ld = ld; v.bl = bl; v.br = br;
        v.pc = pc; v.nop = nop; v.fl = fl; v.fa = a; v.fb = b; v.fc = c;
        return v;
    endfunction

    function automatic logic [3:0] rreg();
        int v = $urandom_range(0, 7);
        if (v < 4) return 4'(v);
        return (v < 6) ? 4'd14 : 4'd15;
    endfunction

    initial begin
        //                rn  rm  rd  urn urm urd rfe ld bl br  pc nop fl  A  B  C
        vecs[0]  = mk(0,  0,  1,  0,  0,  0,  1,  0, 0, 0,  1, 0,  0,  0, 0, 0); // ADD R1
        vecs[1]  = mk(1,  0,  5,  1,  0,  0,  1,  0, 0, 0,  1, 0,  0,  1, 0, 0); // R1 in EX
        vecs[2]  = mk(1,  0,  0,  1,  0,  0,  0,  0, 0, 0,  1, 0,  0,  2, 0, 0); // R1 in MEM
        vecs[3]  = mk(1,  0,  0,  1,  0,  0,  0,  0, 0, 0,  1, 0,  0,  3, 0, 0); // R1 in WB
        vecs[4]  = mk(1,  0,  2,  1,  0,  0,  1,  1, 0, 0,  1, 0,  0,  0, 0, 0); // LDR R2
        vecs[5]  = mk(0,  2,  0,  0,  1,  0,  0,  0, 0, 0,  0, 1,  0,  0, 0, 0); // load-use
        vecs[6]  = mk(0,  2,  0,  0,  1,  0,  0,  0, 0, 0,  1, 0,  0,  0, 2, 0); // release
        vecs[7]  = mk(0,  0,  3,  0,  0,  0,  0,  0, 1, 0,  1, 0,  0,  0, 0, 0); // BL
        vecs[8]  = mk(14, 15, 15, 1,  1,  1,  0,  0, 0, 0,  1, 0,  0,  1, 0, 0);
        vecs[9]  = mk(14, 0,  15, 1,  0,  0,  1,  0, 0, 0,  1, 0,  0,  2, 0, 0); // writes R15
        vecs[10] = mk(15, 0,  14, 1,  0,  1,  0,  0, 0, 0,  1, 0,  0,  0, 0, 3);
        vecs[11] = mk(0,  14, 0,  0,  1,  0,  0,  0, 0, 0,  1, 0,  0,  0, 0, 0);
        vecs[12] = mk(4,  0,  4,  1,  0,  0,  1,  0, 0, 1,  1, 1,  1,  0, 0, 0); // branch
        vecs[13] = mk(4,  0,  0,  1,  0,  0,  0,  0, 0, 0,  1, 0,  0,  0, 0, 0); // flushed R4
        vecs[14] = mk(0,  0,  6,  0,  0,  0,  1,  1, 0, 0,  1, 0,  0,  0, 0, 0); // LDR R6
        vecs[15] = mk(6,  0,  0,  1,  0,  0,  0,  0, 0, 1,  1, 1,  1,  0, 0, 0); // hazard+branch
        vecs[16] = mk(6,  0,  0,  1,  0,  0,  0,  0, 0, 0,  1, 0,  0,  2, 0, 0);

        for (int k = 0; k < 2; k++) begin
            for (int s = 0; s < 3; s++) hist[k][s] = '{0, 0, 0};
            left[k] = 0;
            perf[k] = 0;
        end
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        Reset = 1'b0;
        @(negedge Clk);

        // Reset held two cycles, then released
        step();
        step();
        Reset = 1'b1;
        #1;
        check("rst.PC_enable", pc_en[0], 1);
        check("rst.IF_ID_enable", ifid_en[1], 1);
        check("rst.NOP_select", nop_sel[0], 0);
        check("rst.fwd_A", fa[0], 0);
        check("rst.stall_cycles_u1", sc1, 0);
        check("rst.stall_cycles_u2", sc2, 0);
        step();

        // Directed vector table against the single-bubble instance
        for (int i = 0; i < 17; i++) begin
            set_id(vecs[i].rn, vecs[i].rm, vecs[i].rd, vecs[i].urn, vecs[i].urm, vecs[i].urd,
                   vecs[i].rfe, vecs[i].ld, vecs[i].bl, vecs[i].br);
            #1;
            check($sformatf("vec%0d.PC_enable", i), pc_en[0], vecs[i].pc);
            check($sformatf("vec%0d.IF_ID_enable", i), ifid_en[0], vecs[i].pc);
            check($sformatf("vec%0d.NOP_select", i), nop_sel[0], vecs[i].nop);
            check($sformatf("vec%0d.IF_ID_flush", i), flush[0], vecs[i].fl);
            check($sformatf("vec%0d.fwd_A", i), fa[0], vecs[i].fa);
            check($sformatf("vec%0d.fwd_B", i), fb[0], vecs[i].fb);
            check($sformatf("vec%0d.fwd_C", i), fc[0], vecs[i].fc);
            step();
        end
        check("table.stall_cycles_u1", sc1, 1);

        // Two-bubble stall cut short by a taken branch in its second cycle
        do_reset();
        set_id(0, 0, 2, 0, 0, 0, 1, 1, 0, 0);
        step();
        set_id(0, 2, 0, 0, 1, 0, 0, 0, 0, 0);
        #1;
        check("br_stall.PC_enable_c1", pc_en[1], 0);
        check("br_stall.NOP_select_c1", nop_sel[1], 1);
        step();
        EX_branch_taken = 1'b1;
        #1;
        check("br_stall.IF_ID_flush", flush[1], 1);
        check("br_stall.PC_enable_c2", pc_en[1], 1);
        check("br_stall.IF_ID_enable_c2", ifid_en[1], 1);
        step();
        check("br_stall.stall_cycles", sc2, 1);
        EX_branch_taken = 1'b0;
        #1;
        check("br_stall.idle_PC_enable", pc_en[1], 1);
        check("br_stall.idle_NOP_select", nop_sel[1], 0);
        step();

        // Back-to-back dependent loads until the 4-bit counter saturates
        do_reset();
        set_id(2, 0, 2, 1, 0, 0, 1, 1, 0, 0);
        for (int i = 0; i < 40; i++) step();
        check("sat.stall_cycles_u2", sc2, 15);

        // Reset asserted while in the middle of a stall window
        do_reset();
        set_id(0, 0, 3, 0, 0, 0, 1, 1, 0, 0);
        step();
        set_id(3, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        step();
        Reset = 1'b0;
        step();
        Reset = 1'b1;
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        check("midrst.PC_enable", pc_en[1], 1);
        check("midrst.NOP_select", nop_sel[1], 0);
        check("midrst.stall_cycles", sc2, 0);
        step();

        // Random traffic over a small register set to provoke frequent dependencies
        for (int i = 0; i < 1500; i++) begin
            Reset         = ($urandom_range(0, 63) != 0);
            ID_Rn         = rreg();
            ID_Rm         = rreg();
            ID_Rd         = rreg();
            ID_use_Rn     = 1'($urandom_range(0, 1));
            ID_use_Rm     = 1'($urandom_range(0, 1));
            ID_use_Rd     = ($urandom_range(0, 3) == 0);
            ID_RF_enable  = 1'($urandom_range(0, 1));
            ID_load_instr = ($urandom_range(0, 2) == 0);
            ID_BL_instr   = ($urandom_range(0, 7) == 0);
            EX_branch_taken = ($urandom_range(0, 9) == 0);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
